// File: rtl/l2_l1_directory_if.sv
// ============================================================================
// l2_l1_directory_if : lookup / update / clear bundle for the L2 shadow L1 tags
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface l2_l1_directory_if #(
  parameter int NUM_CORES    = 4,
  parameter int L1_SETS      = 64,
  parameter int L1_WAYS      = 4,
  parameter int L1_TAG_WIDTH = 20
);
  localparam int SET_W  = $clog2(L1_SETS);
  localparam int CORE_W = $clog2(NUM_CORES);
  localparam int CNT_W  = $clog2(L1_SETS * L1_WAYS) + 1;

  logic                          lookup_valid;
  logic [L1_TAG_WIDTH-1:0]       lookup_tag;
  logic [SET_W-1:0]              lookup_set;
  logic [NUM_CORES-1:0]          l1_has_line;
  logic [NUM_CORES*2-1:0]        l1_way;
  logic                          update_enable;
  logic [CORE_W-1:0]             update_core;
  logic [SET_W-1:0]              update_set;
  logic [1:0]                    update_way;
  logic [L1_TAG_WIDTH-1:0]       update_tag;
  logic                          update_valid;
  logic                          clear_core;
  logic [CORE_W-1:0]             clear_core_id;
  logic [NUM_CORES*CNT_W-1:0]    lines_held;

  modport master (
    output lookup_valid, lookup_tag, lookup_set,
    output update_enable, update_core, update_set, update_way, update_tag, update_valid,
    output clear_core, clear_core_id,
    input  l1_has_line, l1_way, lines_held
  );

  modport slave (
    input  lookup_valid, lookup_tag, lookup_set,
    input  update_enable, update_core, update_set, update_way, update_tag, update_valid,
    input  clear_core, clear_core_id,
    output l1_has_line, l1_way, lines_held
  );
endinterface

`default_nettype wire

// File: rtl/l2_l1_directory.sv
// ============================================================================
// l2_l1_directory : per-core shadow of L1 D-cache tags with 1-cycle lookup
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module l2_l1_directory #(
  parameter int NUM_CORES    = 4,
  parameter int L1_SETS      = 64,
  parameter int L1_WAYS      = 4,
  parameter int L1_TAG_WIDTH = 20
) (
  input  logic              clk,
  input  logic              reset,
  l2_l1_directory_if.slave  dir
);

  localparam int SET_W  = $clog2(L1_SETS);
  localparam int CORE_W = $clog2(NUM_CORES);
  localparam int WAY_W  = 2;
  localparam int CNT_W  = $clog2(L1_SETS * L1_WAYS) + 1;
  localparam int ADDR_W = CORE_W + SET_W + WAY_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic [L1_WAYS-1:0]       r_valid [NUM_CORES][L1_SETS];
  logic [L1_TAG_WIDTH-1:0]  r_tag_mem [DEPTH];
  logic [CNT_W-1:0]         r_lines_held [NUM_CORES];
  logic [NUM_CORES-1:0]     r_has_line;
  logic [NUM_CORES*WAY_W-1:0] r_way;

  logic                     w_upd_go;
  logic                     w_cur_valid;
  logic [ADDR_W-1:0]        w_upd_addr;
  logic [NUM_CORES-1:0]     w_hit;
  logic [NUM_CORES*WAY_W-1:0] w_way_idx;

  function automatic logic [WAY_W-1:0] f_way_enc(input logic [L1_WAYS-1:0] m);
    f_way_enc = '0;
    for (int w = 0; w < L1_WAYS; w++) begin
      if (m[w]) f_way_enc = WAY_W'(w);
    end
  endfunction

  // A clear of the same core discards the update entirely
  assign w_upd_go    = dir.update_enable &&
                       !(dir.clear_core && (dir.clear_core_id == dir.update_core));
  assign w_cur_valid = r_valid[dir.update_core][dir.update_set][dir.update_way];
  assign w_upd_addr  = {dir.update_core, dir.update_set, dir.update_way};

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    logic [L1_WAYS-1:0] w_match;
    logic               w_cleared;

    assign w_cleared = dir.clear_core && (dir.clear_core_id == CORE_W'(c));

    for (genvar w = 0; w < L1_WAYS; w++) begin : g_way
      logic                    w_byp;
      logic                    w_eff_valid;
      logic [L1_TAG_WIDTH-1:0] w_eff_tag;

      // Same-cycle update to this entry is seen as already written
      assign w_byp = w_upd_go && (dir.update_core == CORE_W'(c)) &&
                     (dir.update_set == dir.lookup_set) && (dir.update_way == WAY_W'(w));
      assign w_eff_valid = !w_cleared &&
                           (w_byp ? dir.update_valid : r_valid[c][dir.lookup_set][w]);
      assign w_eff_tag   = (w_byp && dir.update_valid) ? dir.update_tag :
                           r_tag_mem[{CORE_W'(c), dir.lookup_set, WAY_W'(w)}];
      assign w_match[w]  = w_eff_valid && (w_eff_tag == dir.lookup_tag);
    end

    assign w_hit[c]                     = |w_match;
    assign w_way_idx[c*WAY_W +: WAY_W]  = f_way_enc(w_match);
    assign dir.lines_held[c*CNT_W +: CNT_W] = r_lines_held[c];

    a_onehot_match: assert property (@(posedge clk) disable iff (reset)
      dir.lookup_valid |-> $onehot0(w_match));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        for (int s = 0; s < L1_SETS; s++) begin
          r_valid[c][s] <= '0;
        end
        r_lines_held[c] <= '0;
      end
      r_has_line <= '0;
      r_way      <= '0;
    end else begin
      r_has_line <= dir.lookup_valid ? w_hit : '0;
      r_way      <= dir.lookup_valid ? w_way_idx : '0;

      if (w_upd_go) begin
        r_valid[dir.update_core][dir.update_set][dir.update_way] <= dir.update_valid;
        if (dir.update_valid && !w_cur_valid) begin
          r_lines_held[dir.update_core] <= r_lines_held[dir.update_core] + CNT_W'(1);
        end else if (!dir.update_valid && w_cur_valid) begin
          r_lines_held[dir.update_core] <= r_lines_held[dir.update_core] - CNT_W'(1);
        end
      end

      if (dir.clear_core) begin
        for (int s = 0; s < L1_SETS; s++) begin
          r_valid[dir.clear_core_id][s] <= '0;
        end
        r_lines_held[dir.clear_core_id] <= '0;
      end
    end
  end

  // Tags are written only on allocate; invalidate keeps the old tag
  always_ff @(posedge clk) begin
    if (w_upd_go && dir.update_valid) begin
      r_tag_mem[w_upd_addr] <= dir.update_tag;
    end
  end

  assign dir.l1_has_line = r_has_line;
  assign dir.l1_way      = r_way;

endmodule

`default_nettype wire

// File: tb/tb_l2_l1_directory.sv
// ============================================================================
// tb_l2_l1_directory : scoreboard bench with an array-based reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_l2_l1_directory;

  localparam int NC   = 4;
  localparam int SETS = 64;
  localparam int WAYS = 4;
  localparam int TW   = 20;
  localparam int CW   = 9;

  typedef struct {
    int                 due;
    logic [NC-1:0]      has;
    logic [NC*2-1:0]    way;
    logic [NC*CW-1:0]   held;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  bit            mvalid [NC][SETS][WAYS];
  logic [TW-1:0] mtag   [NC][SETS][WAYS];

  l2_l1_directory_if #(.NUM_CORES(NC), .L1_SETS(SETS), .L1_WAYS(WAYS), .L1_TAG_WIDTH(TW)) dif ();

  l2_l1_directory #(.NUM_CORES(NC), .L1_SETS(SETS), .L1_WAYS(WAYS), .L1_TAG_WIDTH(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .dir   (dif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp, input int due);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", name, due, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++)
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) mvalid[c][s][w] = 1'b0;
  endtask

  // Resident-line count is simply the number of valid entries a core owns
  function automatic logic [NC*CW-1:0] model_held();
    logic [NC*CW-1:0] h;
    h = '0;
    for (int c = 0; c < NC; c++) begin
      int cnt;
      cnt = 0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) cnt += int'(mvalid[c][s][w]);
      h[c*CW +: CW] = CW'(cnt);
    end
    return h;
  endfunction

  task automatic step(input bit lv, input int lset, input logic [TW-1:0] ltag,
                      input bit ue, input int ucore, input int uset, input int uway,
                      input logic [TW-1:0] utag, input bit uval,
                      input bit cc, input int ccid);
    exp_t e;
    bit   kill;
    @(posedge clk); #1;
    kill = cc && (ccid == ucore);
    if (cc)
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) mvalid[ccid][s][w] = 1'b0;
    // Never create two matching ways for one core and set
    if (ue && !kill && uval)
      for (int w = 0; w < WAYS; w++)
        if (w != uway && mvalid[ucore][uset][w] && mtag[ucore][uset][w] == utag) uval = 1'b0;
    if (ue && !kill) begin
      mvalid[ucore][uset][uway] = uval;
      if (uval) mtag[ucore][uset][uway] = utag;
    end
    dif.lookup_valid  = lv;
    dif.lookup_set    = 6'(lset);
    dif.lookup_tag    = ltag;
    dif.update_enable = ue;
    dif.update_core   = 2'(ucore);
    dif.update_set    = 6'(uset);
    dif.update_way    = 2'(uway);
    dif.update_tag    = utag;
    dif.update_valid  = uval;
    dif.clear_core    = cc;
    dif.clear_core_id = 2'(ccid);
    e.has = '0;
    e.way = '0;
    if (lv)
      for (int c = 0; c < NC; c++)
        for (int w = 0; w < WAYS; w++)
          if (mvalid[c][lset][w] && mtag[c][lset][w] == ltag) begin
            e.has[c]       = 1'b1;
            e.way[c*2 +: 2] = 2'(w);
          end
    e.held = model_held();
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic lookup(input int lset, input logic [TW-1:0] ltag);
    step(1, lset, ltag, 0, 0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic upd(input int core, input int set, input int way, input logic [TW-1:0] tag, input bit v);
    step(0, 0, '0, 1, core, set, way, tag, v, 0, 0);
  endtask

  // Monitor: each registered result appears after the edge its inputs were sampled on
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #3;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check("l1_has_line", 64'(dif.l1_has_line), 64'(e.has), e.due);
        check("l1_way", 64'(dif.l1_way), 64'(e.way), e.due);
        check("lines_held", 64'(dif.lines_held), 64'(e.held), e.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout cycle=%0d got=running exp=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    dif.lookup_valid = 0; dif.lookup_set = '0; dif.lookup_tag = '0;
    dif.update_enable = 0; dif.update_core = '0; dif.update_set = '0; dif.update_way = '0;
    dif.update_tag = '0; dif.update_valid = 0; dif.clear_core = 0; dif.clear_core_id = '0;
    model_reset();
    #12 reset = 1'b0;
    #1;
    check("reset_has_line", 64'(dif.l1_has_line), 64'd0, cyc);
    check("reset_way", 64'(dif.l1_way), 64'd0, cyc);
    check("reset_lines_held", 64'(dif.lines_held), 64'd0, cyc);

    lookup(5, 20'h123);
    upd(2, 5, 3, 20'h123, 1);
    lookup(5, 20'h123);
    upd(2, 5, 3, 20'h123, 1);
    lookup(5, 20'h123);

    step(1, 9, 20'hABC, 1, 1, 9, 0, 20'hABC, 1, 0, 0);
    step(1, 9, 20'hABC, 1, 1, 9, 0, 20'hABC, 0, 0, 0);

    for (int w = 0; w < 4; w++) upd(0, 9, w, 20'h10 + 20'(w), 1);
    lookup(9, 20'h12);
    step(1, 9, 20'h11, 1, 0, 10, 0, 20'h55, 1, 1, 0);
    for (int w = 0; w < 4; w++) lookup(9, 20'h10 + 20'(w));
    lookup(10, 20'h55);

    upd(1, 20, 1, 20'h77, 0);
    lookup(20, 20'h77);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 3), 20'h200 + 20'($urandom_range(0, 7)),
           ($urandom_range(0, 9) < 7), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           20'h200 + 20'($urandom_range(0, 7)), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 39) == 0), $urandom_range(0, 3));
    end

    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) upd(3, s, w, 20'hF0000 + 20'(w), 1);
    lookup(0, 20'hF0000);

    // Async reset between edges, right after a hitting lookup result appears
    @(posedge clk); #5;
    dif.lookup_valid = 0; dif.update_enable = 0; dif.clear_core = 0;
    reset = 1'b1;
    #1;
    check("async_has_line", 64'(dif.l1_has_line), 64'd0, cyc);
    check("async_way", 64'(dif.l1_way), 64'd0, cyc);
    check("async_lines_held", 64'(dif.lines_held), 64'd0, cyc);
    model_reset();
    begin
      exp_t e;
      e.has = '0; e.way = '0; e.held = '0; e.due = cyc + 1;
      sb.push_back(e);
    end
    #2 reset = 1'b0;
    lookup(0, 20'hF0000);
    lookup(5, 20'h123);

    step(0, 0, '0, 0, 0, 0, 0, '0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #5;
    check("scoreboard_drained", 64'(sb.size()), 64'd0, cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
